writeback_queue: RTL
====================

# writeback_queue

Small in-order write-back buffer that sits between the datapath's result sources and the register file's single write port. It accepts (rd, data) write requests over a valid/ready handshake, holds them in a FIFO, and drains one entry per cycle into the register file. It also provides a combinational bypass lookup so rs1/rs2 reads see pending, not-yet-written values.

## Interface
- DEPTH, 4, number of pending entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  write request present
- in_ready  output  1  queue can accept a request this cycle
- in_rd  input  5  destination register of request
- in_data  input  32  value to write
- rf_hold  input  1  when high, no drain this cycle
- rf_write_enable  output  1  drives register file RegWrite
- rf_rd  output  5  drives register file rd
- rf_din  output  32  drives register file rd_din
- rs1  input  5  bypass lookup index 1
- rs2  input  5  bypass lookup index 2
- rs1_hit  output  1  rs1 matches a pending entry
- rs1_data  output  32  youngest pending value for rs1
- rs2_hit  output  1  rs2 matches a pending entry
- rs2_data  output  32  youngest pending value for rs2
- count  output  $clog2(DEPTH)+1  number of pending entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

## Operation
- Storage: circular FIFO of DEPTH entries {rd[4:0], data[31:0]}, head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Accept: occurs when in_valid && in_ready at a rising edge. in_ready = !full. It is derived from the registered count only; no same-cycle pass-through when full.
- x0 requests: a request with in_rd == 0 is accepted (handshake completes) but is not stored. count does not change.
- Drain: rf_write_enable = !empty && !rf_hold. While it is high, rf_rd/rf_din are the head entry, and the head pops at the next rising edge.
- When rf_write_enable is low, rf_rd = 0 and rf_din = 0.
- Simultaneous accept and drain: both occur in the same cycle, and count is unchanged.
  - Full with drain: in_ready is still low that cycle; the freed slot is offered in the next cycle.
- Ordering: drains follow strict FIFO order. Duplicate rd entries are not coalesced; each one is written in order.
- Bypass: combinational match over all valid entries.
  - Matches on rs == entry.rd with rs != 0.
  - On multiple matches, the youngest (closest to tail) entry wins.
  - The head entry being drained this cycle still participates in the match.
  - With no match: hit = 0 and data = 0.
  - rs == 0 never hits.
- The bypass does not observe in_data of a request being accepted this cycle.
- Reset (asynchronous, including mid-operation): pointers and count clear, and all pending entries are discarded without being written.
  - in_ready=1, empty=1, full=0, count=0.
  - rf_write_enable=0, rf_rd=0, rf_din=0.
  - rs1_hit=rs2_hit=0, rs1_data=rs2_data=0.

## Timing
- Accept at edge N; the entry is visible on the bypass and at count from just after N.
- If the queue was empty and rf_hold=0, rf_write_enable is high in cycle N→N+1, and the register file captures the value at edge N+1.
- Throughput: one accept and one drain per cycle sustained.
- Drain latency for an entry: (entries ahead of it + cycles rf_hold is high) + 1 cycles.
- The bypass to register-file handoff is seamless. An entry drained at edge M is absent from the queue after M, exactly when the register file's synchronous write makes it readable.
- rf_hold is sampled combinationally; asserting it in a cycle suppresses that cycle's write and pop only.
- Outputs in_ready, empty, full and count depend only on registered state.
- rf_write_enable depends on state and rf_hold.
- The bypass outputs depend on state and rs1/rs2.

## Test plan
- Reset → count=0, empty=1, full=0, in_ready=1, rf_write_enable=0, rs1_hit=0. Assert reset with 3 entries pending → same values immediately, before the next edge, and no write occurs.
- Push rd=5, data=32'hDEADBEEF with rf_hold=0 → next cycle rf_write_enable=1, rf_rd=5, rf_din=32'hDEADBEEF; the cycle after, empty=1 and rf_write_enable=0.
- rf_hold=1, push rd=1..4 with data=32'h11..32'h44 → full=1, in_ready=0, and a fifth push is not accepted. Release hold → writes rd=1,2,3,4 in order on 4 consecutive cycles, then empty=1.
- rf_hold=1, push rd=3/data=1 then rd=3/data=2 → rs1=3 gives rs1_hit=1, rs1_data=2; rs2=0 gives rs2_hit=0, rs2_data=0. Release hold → two writes to x3 (1 then 2).
- Push with in_rd=0, data=32'hFFFFFFFF → handshake completes, count stays 0, rf_write_enable never asserts.
- Steady stream: in_valid=1 every cycle with rf_hold=0 for 20 cycles, rd=1..20 mod 32 skipping 0 → count never exceeds 1, every value is written exactly once in order, and in_ready stays 1.

Source files
------------

// File: rtl/writeback_queue.sv
// In-order write-back buffer between result sources and the register file write port.
// Accepts (rd, data) requests, drains one per cycle, and offers a youngest-wins bypass lookup.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    input  logic                     rf_hold,
    output logic                     rf_write_enable,
    output logic [4:0]               rf_rd,
    output logic [31:0]              rf_din,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     rs1_hit,
    output logic [31:0]              rs1_data,
    output logic                     rs2_hit,
    output logic [31:0]              rs2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [4:0]  rd_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic push;
    logic pop;

    // Status comes from registered count only, so a full queue never accepts
    // in the same cycle it drains.
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = count_reg;

    // x0 requests complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_rd != 5'd0);
    assign pop  = !empty && !rf_hold;

    assign rf_write_enable = pop;
    assign rf_rd           = pop ? rd_mem[head_reg]   : 5'd0;
    assign rf_din          = pop ? data_mem[head_reg] : 32'd0;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop) begin
            head_next = head_reg + PTR_W'(1);
        end
        if (push) begin
            tail_next = tail_reg + PTR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload storage needs no reset: liveness is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_reg]   <= in_rd;
            data_mem[tail_reg] <= in_data;
        end
    end

    logic [PTR_W-1:0] slot_age [DEPTH];
    logic [DEPTH-1:0] slot_live;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Age is the slot's distance from head; live slots have age < count.
            assign slot_age[gi]  = PTR_W'(gi) - head_reg;
            assign slot_live[gi] = ({1'b0, slot_age[gi]} < count_reg);
            assign match1[gi]    = slot_live[gi] && (rs1 != 5'd0) && (rd_mem[gi] == rs1);
            assign match2[gi]    = slot_live[gi] && (rs2 != 5'd0) && (rd_mem[gi] == rs2);
        end
    endgenerate

    // Walk from oldest to youngest so the last match found is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        rs1_hit  = 1'b0;
        rs1_data = 32'd0;
        rs2_hit  = 1'b0;
        rs2_data = 32'd0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PTR_W'(k);
            if (match1[idx]) begin
                rs1_hit  = 1'b1;
                rs1_data = data_mem[idx];
            end
            if (match2[idx]) begin
                rs2_hit  = 1'b1;
                rs2_data = data_mem[idx];
            end
        end
    end

endmodule
